apb_slave_mem: RTL

APB responder with a word-addressed register memory. It is the far end of the team's APB master: it accepts setup/access phases and inserts a programmable number of wait states through Pready. It signals Pslverr on misaligned or out-of-range addresses. It is the target peripheral for the AHB-to-APB bridge and for master-side verification.

---
 rtl/apb_slave_mem.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB responder backed by a word-addressed register memory.
// Completes each transfer after WAIT_CYCLES wait states and flags misaligned or out-of-range accesses.
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Pclk,
    input  logic        Presetn,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int unsigned IDXW      = $clog2(DEPTH);
    localparam logic [32:0] SPAN      = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] mem_q [DEPTH];

    logic        memWe;
    logic        cmplEn;
    logic [31:0] cmplAddr;
    logic        cmplWrite;
    logic        cmplErr;

    // A borrow from the 33-bit subtraction lands above SPAN, so one compare covers both range ends.
    function automatic logic addrErr(input logic [31:0] a);
        logic [32:0] offs;
        offs = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a[1:0] != 2'b00) || (offs >= SPAN);
    endfunction

    function automatic logic [IDXW-1:0] addrIdx(input logic [31:0] a);
        return IDXW'((a - BASE_ADDR) >> 2);
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        waitCnt_d = waitCnt_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        memWe     = 1'b0;
        cmplEn    = 1'b0;
        cmplAddr  = addr_q;
        cmplWrite = write_q;
        cmplErr   = err_q;

        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                if (Psel && !Penable) begin
                    addr_d  = Paddr;
                    write_d = Pwrite;
                    wdata_d = Pdata;
                    err_d   = addrErr(Paddr);
                    if (WAIT_CYCLES == 0) begin
                        cmplEn    = 1'b1;
                        cmplAddr  = Paddr;
                        cmplWrite = Pwrite;
                        cmplErr   = addrErr(Paddr);
                        state_d   = DONE;
                    end else begin
                        waitCnt_d = WAIT_INIT;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!Psel) begin
                    waitCnt_d = 4'd0;
                    state_d   = IDLE;
                end else if (Penable) begin
                    if (waitCnt_q == 4'd1) begin
                        cmplEn    = 1'b1;
                        waitCnt_d = 4'd0;
                        state_d   = DONE;
                    end else begin
                        waitCnt_d = waitCnt_q - 4'd1;
                    end
                end
            end
            DONE: begin
                if (!Psel) begin
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = IDLE;
                end else if (Penable) begin
                    memWe     = write_q && !err_q;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmplEn) begin
            pready_d  = 1'b1;
            pslverr_d = cmplErr;
            prdata_d  = (!cmplWrite && !cmplErr) ? mem_q[addrIdx(cmplAddr)] : 32'h0;
        end
    end

    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            waitCnt_q <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            waitCnt_q <= waitCnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            if (memWe) begin
                mem_q[addrIdx(addr_q)] <= wdata_q;
            end
        end
    end

    assign Prdata  = prdata_q;
    assign Pready  = pready_q;
    assign Pslverr = pslverr_q;

endmodule
